// File: rtl/tmac_uni_win_pkg.sv
// Shared types and helpers for the windowed unipolar stochastic MAC:
// the controller state encoding, the bit-reversal (van der Corput)
// helper used as the comparison sequence, and the sum-width helper.
package tmac_pkg;

    // Widest operand width the bit-reversal helper supports.
    localparam int REV_MAX_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_SUM1 = 3'd2,
        ST_SUM2 = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    // Reverse the low w bits of x. The full REV_MAX_W-bit vector is
    // reversed and shifted down so the result lands in bits [w-1:0].
    function automatic logic [REV_MAX_W-1:0] rev(input logic [REV_MAX_W-1:0] x,
                                                 input int                   w);
        logic [REV_MAX_W-1:0] y;
        y = {<<{x}};
        return y >> (REV_MAX_W - w);
    endfunction

    // Width of the full adder-tree sum: every lane may reach 2^width-1.
    function automatic int sum_width(input int width, input int n_lane);
        return width + $clog2(n_lane);
    endfunction

endpackage

// File: rtl/tmac_uni_win_if.sv
// Handshake and operand bus of the windowed stochastic MAC.
// The master side issues start/clear and operands; the slave side
// (the MAC) returns busy/done, the binary result and the bitstream.
interface tmac_uni_win_if #(
    parameter int N_LANE = 16,
    parameter int WIDTH  = 8
);
    logic                          start;
    logic                          clear;
    logic [N_LANE-1:0][WIDTH-1:0]  iA;
    logic [N_LANE-1:0][WIDTH-1:0]  iB;
    logic                          busy;
    logic                          done;
    logic [WIDTH-1:0]              result;
    logic                          oC;
    logic                          oValid;

    modport master (
        output start, clear, iA, iB,
        input  busy, done, result, oC, oValid
    );

    modport slave (
        input  start, clear, iA, iB,
        output busy, done, result, oC, oValid
    );

endinterface

// File: rtl/tmac_uni_win_lane.sv
// One product lane: captures its rate-coded operand A and temporal
// operand B at accept, then counts cycles where A beats the
// low-discrepancy sequence while the window index is still below B.
module tmul_uni_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_rng,
    input  logic [WIDTH-1:0] i_wcnt,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_count;
    logic             w_bit;

    // Product bit: rate-coded A against rev(wcnt), gated by temporal B.
    assign w_bit = (r_a > i_rng) && (i_wcnt < r_b);

    // Operand capture; only the accept edge updates A and B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_load && !i_clear) begin
            r_a <= i_a;
            r_b <= i_b;
        end
    end

    // Lane counter; at most 2^WIDTH-1 increments per window so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || i_load) begin
            r_count <= '0;
        end else if (i_en && w_bit) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/tmac_uni_win.sv
// Windowed unipolar stochastic multiply-accumulate. N_LANE lanes run
// for one 2^WIDTH-cycle window, their counts are reduced in two
// registered stages (groups of four, then the total), the total is
// saturated or scaled into a WIDTH-bit result, and that result is
// replayed as a rate-coded bitstream for another 2^WIDTH cycles.
module tmac_uni_win
    import tmac_pkg::*;
#(
    parameter int N_LANE = 16,
    parameter int WIDTH  = 8,
    parameter int SCALED = 0
) (
    input logic           clk,
    input logic           rst_n,
    tmac_uni_win_if.slave bus
);

    localparam int LOG2_N = $clog2(N_LANE);
    localparam int SUM_W  = sum_width(WIDTH, N_LANE);
    localparam int GRP_W  = WIDTH + 2;
    localparam int N_GRP  = N_LANE / 4;
    localparam logic [WIDTH-1:0] W_MAX = '1;

    state_t                        r_state;
    logic [WIDTH-1:0]              r_wcnt;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_valid;
    logic [WIDTH-1:0]              r_result;
    logic [N_GRP-1:0][GRP_W-1:0]   r_part;

    logic [WIDTH-1:0]              w_rng;
    logic                          w_accept;
    logic                          w_run;
    logic [N_LANE-1:0][WIDTH-1:0]  w_cnt;
    logic [N_GRP-1:0][GRP_W-1:0]   w_grp;
    logic [SUM_W-1:0]              w_total;
    logic [WIDTH-1:0]              w_res;

    genvar gi;

    // One shared window counter feeds both the RUN and OUT comparisons.
    assign w_rng    = WIDTH'(rev(REV_MAX_W'(r_wcnt), WIDTH));
    assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.clear;
    assign w_run    = (r_state == ST_RUN);

    for (gi = 0; gi < N_LANE; gi++) begin : g_lane
        tmul_uni_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_accept),
            .i_clear (bus.clear),
            .i_en    (w_run),
            .i_a     (bus.iA[gi]),
            .i_b     (bus.iB[gi]),
            .i_rng   (w_rng),
            .i_wcnt  (r_wcnt),
            .o_count (w_cnt[gi])
        );
    end

    // First tree level: four lane counts per group, two growth bits.
    for (gi = 0; gi < N_GRP; gi++) begin : g_grp
        assign w_grp[gi] = GRP_W'(w_cnt[4*gi])   + GRP_W'(w_cnt[4*gi+1])
                         + GRP_W'(w_cnt[4*gi+2]) + GRP_W'(w_cnt[4*gi+3]);
    end

    // Register the group partial sums during SUM1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_part <= '0;
        end else if ((r_state == ST_SUM1) && !bus.clear) begin
            r_part <= w_grp;
        end
    end

    // Second tree level: walk the packed partial sums with a shift so
    // every slice index stays constant.
    always_comb begin
        logic [N_GRP*GRP_W-1:0] v_flat;
        v_flat  = r_part;
        w_total = '0;
        for (int k = 0; k < N_GRP; k++) begin
            w_total = w_total + SUM_W'(v_flat[GRP_W-1:0]);
            v_flat  = v_flat >> GRP_W;
        end
    end

    // Fold the total into WIDTH bits: truncating scale or saturation.
    always_comb begin
        w_res = '0;
        if (SCALED != 0) begin
            w_res = WIDTH'(w_total >> LOG2_N);
        end else if (w_total > SUM_W'(W_MAX)) begin
            w_res = W_MAX;
        end else begin
            w_res = WIDTH'(w_total);
        end
    end

    // Controller: window sequencing, reduction steps and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_wcnt   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else if (bus.clear) begin
            // Abort keeps the last result but drops everything in flight.
            r_state  <= ST_IDLE;
            r_wcnt   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_RUN;
                        r_wcnt  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_wcnt <= r_wcnt + 1'b1;
                    if (r_wcnt == W_MAX) begin
                        r_state <= ST_SUM1;
                    end
                end
                ST_SUM1: begin
                    r_state <= ST_SUM2;
                end
                ST_SUM2: begin
                    r_state  <= ST_OUT;
                    r_result <= w_res;
                    r_done   <= 1'b1;
                    r_valid  <= 1'b1;
                end
                ST_OUT: begin
                    r_wcnt <= r_wcnt + 1'b1;
                    if (r_wcnt == W_MAX) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.oValid = r_valid;
    // Over the OUT window rev(wcnt) visits every value once, so exactly
    // r_result cycles carry a one.
    assign bus.oC     = r_valid && (r_result > w_rng);

endmodule

// File: tb/tb_tmac_uni_win.sv
// Bench for tmac_uni_win: saturating and scaled 16x8 instances share
// stimulus; a 4x4 instance gets a randomised sweep against a model.
module tb_tmac_uni_win;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tmac_uni_win_if #(.N_LANE(16), .WIDTH(8)) if_s0 ();
    tmac_uni_win_if #(.N_LANE(16), .WIDTH(8)) if_s1 ();
    tmac_uni_win_if #(.N_LANE(4),  .WIDTH(4)) if_w4 ();

    tmac_uni_win #(.N_LANE(16), .WIDTH(8), .SCALED(0)) u_s0 (.clk(clk), .rst_n(rst_n), .bus(if_s0.slave));
    tmac_uni_win #(.N_LANE(16), .WIDTH(8), .SCALED(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(if_s1.slave));
    tmac_uni_win #(.N_LANE(4),  .WIDTH(4), .SCALED(0)) u_w4 (.clk(clk), .rst_n(rst_n), .bus(if_w4.slave));

    typedef logic [15:0][7:0] ops_t;
    typedef struct packed {
        ops_t       a;
        ops_t       b;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int idle_oc_viol = 0;
    int q0[$];
    int q1[$];
    int qw[$];
    int ones0 = 0, win0 = 0, xones0 = 0;
    int onesw = 0, winw = 0, xonesw = 0;
    logic pv0 = 1'b0, pvw = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int rev_m(input int x, input int w);
        int y;
        y = 0;
        for (int k = 0; k < w; k++)
            if (((x >> k) & 1) != 0) y = y | (1 << (w - 1 - k));
        return y;
    endfunction

    function automatic int gold(input ops_t a, input ops_t b, input int n, input int w, input int sc);
        int s, r, mx;
        s = 0;
        mx = (1 << w) - 1;
        for (int t = 0; t < (1 << w); t++) begin
            r = rev_m(t, w);
            for (int i = 0; i < n; i++)
                if (int'(a[i]) > r && t < int'(b[i])) s++;
        end
        if (sc != 0) return s >> $clog2(n);
        return (s > mx) ? mx : s;
    endfunction

    function automatic vec_t mk(input ops_t a, input ops_t b, input int e0, input int e1);
        vec_t v;
        v.a = a; v.b = b; v.e0 = 8'(e0); v.e1 = 8'(e1);
        return v;
    endfunction

    always @(negedge clk) cyc++;

    // Scoreboard for the saturating instance, including the bitstream count.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete(); q1.delete(); qw.delete();
            ones0 = 0; win0 = 0; pv0 = 1'b0;
            onesw = 0; winw = 0; pvw = 1'b0;
        end else begin
            if ((!if_s0.oValid && if_s0.oC) || (!if_s1.oValid && if_s1.oC) || (!if_w4.oValid && if_w4.oC))
                idle_oc_viol++;
            if (if_s0.done) begin
                check("s0_done_expected", 64'(q0.size() > 0), 1);
                if (q0.size() > 0) begin
                    xones0 = q0.pop_front();
                    check("s0_result", if_s0.result, xones0);
                end
            end
            if (if_s0.oValid) begin
                win0++;
                if (if_s0.oC) ones0++;
            end else if (pv0) begin
                check("s0_oc_ones", ones0, xones0);
                check("s0_ovalid_len", win0, 256);
                ones0 = 0; win0 = 0;
            end
            pv0 = if_s0.oValid;
            if (if_s1.done) begin
                check("s1_done_expected", 64'(q1.size() > 0), 1);
                if (q1.size() > 0) check("s1_result", if_s1.result, q1.pop_front());
            end
            if (if_w4.done) begin
                check("w4_done_expected", 64'(qw.size() > 0), 1);
                if (qw.size() > 0) begin
                    xonesw = qw.pop_front();
                    check("w4_result", if_w4.result, xonesw);
                end
            end
            if (if_w4.oValid) begin
                winw++;
                if (if_w4.oC) onesw++;
            end else if (pvw) begin
                check("w4_oc_ones", onesw, xonesw);
                check("w4_ovalid_len", winw, 16);
                onesw = 0; winw = 0;
            end
            pvw = if_w4.oValid;
        end
    end

    task automatic drive8(input ops_t a, input ops_t b, input logic st, input logic cl);
        if_s0.iA = a; if_s1.iA = a;
        if_s0.iB = b; if_s1.iB = b;
        if_s0.start = st; if_s1.start = st;
        if_s0.clear = cl; if_s1.clear = cl;
    endtask

    task automatic start8(input ops_t a, input ops_t b, input int e0, input int e1, output int t0);
        int n;
        n = 0;
        while (if_s0.busy && n < 1200) begin @(posedge clk); #1; n++; end
        check("s0_idle_before_start", if_s0.busy, 0);
        drive8(a, b, 1'b1, 1'b0);
        @(posedge clk);
        q0.push_back(e0); q1.push_back(e1);
        #1;
        t0 = cyc;
        // Operands must already be captured; scramble them from here on.
        drive8(~a, ~b, 1'b0, 1'b0);
    endtask

    task automatic wait_done8(input int t0, output int lat);
        int n;
        n = 0;
        while (!if_s0.done && n < 700) begin @(posedge clk); #1; n++; end
        check("s0_done_seen", if_s0.done, 1);
        check("s1_done_aligned", if_s1.done, 1);
        lat = cyc - t0;
    endtask

    task automatic wait_idle8(input int t0, output int len);
        int n;
        n = 0;
        while (if_s0.busy && n < 700) begin @(posedge clk); #1; n++; end
        check("s0_busy_fell", if_s0.busy, 0);
        len = cyc - t0;
    endtask

    task automatic run8(input vec_t v);
        int t0, lat, len;
        start8(v.a, v.b, int'(v.e0), int'(v.e1), t0);
        wait_done8(t0, lat);
        check("s0_latency", lat, 258);
        wait_idle8(t0, len);
        check("s0_busy_len", len, 514);
        check("s0_result_hold", if_s0.result, v.e0);
        check("s1_result_hold", if_s1.result, v.e1);
        $display("op16x8: sat result=%0d expect=%0d  scaled result=%0d expect=%0d  latency=%0d",
                 if_s0.result, v.e0, if_s1.result, v.e1, lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        ops_t a, b;
        int t0, lat, n_done, e;
        logic [3:0][3:0] wa, wb;

        rst_n = 1'b0;
        drive8('0, '0, 1'b0, 1'b0);
        if_w4.start = 1'b0; if_w4.clear = 1'b0; if_w4.iA = '0; if_w4.iB = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", if_s0.busy, 0);
        check("rst_done", if_s0.done, 0);
        check("rst_ovalid", if_s0.oValid, 0);
        check("rst_oc", if_s0.oC, 0);
        check("rst_result", if_s0.result, 0);
        check("rst_w4_busy", if_w4.busy, 0);
        rst_n = 1'b1;

        a = '0; b = '0; a[0] = 8'd128; b[0] = 8'd200;
        tbl[0] = mk(a, b, 100, 6);
        for (int i = 0; i < 16; i++) begin a[i] = 8'd255; b[i] = 8'd255; end
        tbl[1] = mk(a, b, 255, 255);
        a = '0; b = '0; a[0] = 8'd255; a[1] = 8'd255; b[0] = 8'd200; b[1] = 8'd200;
        tbl[2] = mk(a, b, 255, 25);
        a = '0; for (int i = 0; i < 16; i++) b[i] = 8'd255;
        tbl[3] = mk(a, b, 0, 0);
        b = '0; for (int i = 0; i < 16; i++) a[i] = 8'd255;
        tbl[4] = mk(a, b, 0, 0);
        a = '0; b = '0; a[0] = 8'd255; b[0] = 8'd255;
        tbl[5] = mk(a, b, 255, 15);
        a[1] = 8'd128; b[1] = 8'd2;
        tbl[6] = mk(a, b, 255, 16);
        for (int i = 0; i < 16; i++) begin a[i] = 8'(i * 17); b[i] = 8'(255 - i * 13); end
        tbl[7] = mk(a, b, gold(a, b, 16, 8, 0), gold(a, b, 16, 8, 1));
        for (int i = 0; i < 16; i++) begin a[i] = 8'($urandom_range(0, 255)); b[i] = 8'($urandom_range(0, 255)); end
        tbl[8] = mk(a, b, gold(a, b, 16, 8, 0), gold(a, b, 16, 8, 1));

        for (int i = 0; i < 9; i++) run8(tbl[i]);

        // start during RUN and in the final OUT cycle is ignored
        start8(tbl[0].a, tbl[0].b, 100, 6, t0);
        repeat (50) @(posedge clk);
        #1; if_s0.start = 1'b1; if_s1.start = 1'b1;
        @(posedge clk);
        #1; if_s0.start = 1'b0; if_s1.start = 1'b0;
        wait_done8(t0, lat);
        check("ign_run_latency", lat, 258);
        while (cyc - t0 < 513) begin @(posedge clk); #1; end
        if_s0.start = 1'b1; if_s1.start = 1'b1;
        @(posedge clk);
        #1; if_s0.start = 1'b0; if_s1.start = 1'b0;
        check("ign_last_out_busy", if_s0.busy, 0);
        repeat (4) @(posedge clk);
        #1;
        check("ign_stays_idle", if_s0.busy, 0);
        run8(tbl[2]);

        // clear at cycle 100 of RUN
        start8(tbl[7].a, tbl[7].b, int'(tbl[7].e0), int'(tbl[7].e1), t0);
        while (cyc - t0 < 100) begin @(posedge clk); #1; end
        if_s0.clear = 1'b1; if_s1.clear = 1'b1;
        @(posedge clk);
        #1; if_s0.clear = 1'b0; if_s1.clear = 1'b0;
        void'(q0.pop_back()); void'(q1.pop_back());
        check("clr_busy_low", if_s0.busy, 0);
        check("clr_done_low", if_s0.done, 0);
        n_done = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (if_s0.done || if_s1.done || if_s0.oValid) n_done++;
        end
        check("clr_no_done", n_done, 0);
        check("clr_result_kept_s0", if_s0.result, 255);
        check("clr_result_kept_s1", if_s1.result, 25);
        run8(tbl[7]);

        // asynchronous reset in the middle of OUT
        start8(tbl[1].a, tbl[1].b, 255, 255, t0);
        wait_done8(t0, lat);
        repeat (40) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        check("rstout_busy", if_s0.busy, 0);
        check("rstout_ovalid", if_s0.oValid, 0);
        check("rstout_oc", if_s0.oC, 0);
        check("rstout_done", if_s0.done, 0);
        check("rstout_result_s0", if_s0.result, 0);
        check("rstout_result_s1", if_s1.result, 0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        run8(tbl[0]);

        // WIDTH=4, N_LANE=4 sweep against the model
        for (int k = 0; k < 12; k++) begin
            a = '0; b = '0;
            for (int l = 0; l < 4; l++) begin
                wa[l] = (k == 0) ? 4'hf : 4'($urandom_range(0, 15));
                wb[l] = (k == 0) ? 4'hf : 4'($urandom_range(0, 15));
                a[l] = {4'h0, wa[l]};
                b[l] = {4'h0, wb[l]};
            end
            e = gold(a, b, 4, 4, 0);
            if_w4.iA = wa; if_w4.iB = wb; if_w4.start = 1'b1;
            @(posedge clk);
            qw.push_back(e);
            #1;
            t0 = cyc;
            if_w4.start = 1'b0; if_w4.iA = ~wa; if_w4.iB = ~wb;
            n_done = 0;
            while (!if_w4.done && n_done < 100) begin @(posedge clk); #1; n_done++; end
            check("w4_done_seen", if_w4.done, 1);
            check("w4_latency", cyc - t0, 18);
            n_done = 0;
            while (if_w4.busy && n_done < 100) begin @(posedge clk); #1; n_done++; end
            check("w4_busy_len", cyc - t0, 34);
            check("w4_result_hold", if_w4.result, e);
            $display("op4x4: result=%0d expect=%0d", if_w4.result, e);
        end

        @(posedge clk);
        #1;
        check("oc_low_when_invalid", idle_oc_viol, 0);
        check("queues_drained", q0.size() + q1.size() + qw.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
